// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use and MDU interlocks, branch flush priority,
// multiply/divide launch FSM with busy timeout, and a saturating stall counter.
module hazard_control_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_ex_mem_read,
    input  logic [4:0]  id_ex_write_reg_addr,
    input  logic [4:0]  if_id_instr_rs,
    input  logic [4:0]  if_id_instr_rt,
    input  logic        if_id_uses_rt,
    input  logic        ex_branch_taken,
    input  logic        id_mdu_req,
    input  logic        id_hilo_read,
    input  logic        mdu_done,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mdu_start,
    output logic        mdu_busy,
    output logic        mdu_timeout,
    output logic [15:0] stall_cycles
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [6:0] BUSY_LIMIT = 7'd63;

    state_t     state;
    logic [6:0] busy_cnt;
    logic       load_use;
    logic       mdu_wait;
    logic       stall;
    logic       branch_flush;

    always_comb begin
        load_use = id_ex_mem_read && (id_ex_write_reg_addr != 5'd0) &&
                   ((id_ex_write_reg_addr == if_id_instr_rs) ||
                    (if_id_uses_rt && (id_ex_write_reg_addr == if_id_instr_rt)));
        mdu_wait = (state == BUSY) && !mdu_done && (id_mdu_req || id_hilo_read);
    end

    // Reset forces the free-running pipeline view regardless of input state.
    assign stall        = !rst && (load_use || mdu_wait) && !ex_branch_taken;
    assign branch_flush = !rst && ex_branch_taken;

    assign pc_write    = !stall;
    assign if_id_write = !stall;
    assign if_id_flush = branch_flush;
    assign id_ex_flush = branch_flush || stall;
    assign mdu_start   = !rst && (state == IDLE) && id_mdu_req && !stall && !ex_branch_taken;
    assign mdu_busy    = (state == BUSY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy_cnt    <= 7'd0;
            mdu_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mdu_start) begin
                        state    <= BUSY;
                        busy_cnt <= 7'd0;
                    end
                end
                BUSY: begin
                    busy_cnt <= busy_cnt + 7'd1;
                    if (mdu_done) begin
                        state <= IDLE;
                    end else if (busy_cnt == BUSY_LIMIT) begin
                        // 64th busy cycle ended without a result: give up on it.
                        state       <= IDLE;
                        mdu_timeout <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= 16'd0;
        else if (stall && (stall_cycles != 16'hFFFF))
            stall_cycles <= stall_cycles + 16'd1;
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Randomized + scenario bench: a rule-level model predicts each cycle's outputs
// into a queue; a negedge monitor pops and compares against the DUT.
module tb_hazard_control_unit;

    typedef struct packed {
        bit       rst;
        bit       mr;
        bit [4:0] wr;
        bit [4:0] rs;
        bit [4:0] rt;
        bit       urt;
        bit       br;
        bit       req;
        bit       hilo;
        bit       done;
    } in_t;

    typedef struct packed {
        bit        pc_write;
        bit        if_id_write;
        bit        if_id_flush;
        bit        id_ex_flush;
        bit        mdu_start;
        bit        mdu_busy;
        bit        mdu_timeout;
        bit [15:0] stall_cycles;
    } out_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_ex_mem_read;
    logic [4:0]  id_ex_write_reg_addr;
    logic [4:0]  if_id_instr_rs;
    logic [4:0]  if_id_instr_rt;
    logic        if_id_uses_rt;
    logic        ex_branch_taken;
    logic        id_mdu_req;
    logic        id_hilo_read;
    logic        mdu_done;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        mdu_start;
    logic        mdu_busy;
    logic        mdu_timeout;
    logic [15:0] stall_cycles;

    hazard_control_unit dut (
        .clk(clk), .rst(rst),
        .id_ex_mem_read(id_ex_mem_read),
        .id_ex_write_reg_addr(id_ex_write_reg_addr),
        .if_id_instr_rs(if_id_instr_rs),
        .if_id_instr_rt(if_id_instr_rt),
        .if_id_uses_rt(if_id_uses_rt),
        .ex_branch_taken(ex_branch_taken),
        .id_mdu_req(id_mdu_req),
        .id_hilo_read(id_hilo_read),
        .mdu_done(mdu_done),
        .pc_write(pc_write),
        .if_id_write(if_id_write),
        .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush),
        .mdu_start(mdu_start),
        .mdu_busy(mdu_busy),
        .mdu_timeout(mdu_timeout),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Reference model state: is an MDU op outstanding, how long, sticky error, stall tally.
    bit   m_busy;
    int   m_busy_cycles;
    bit   m_tmo;
    int   m_stalls;
    in_t  prev;
    out_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic out_t predict(in_t x);
        out_t o;
        bit lu, wt, st;
        lu = x.mr && x.wr != 0 && (x.wr == x.rs || (x.urt && x.wr == x.rt));
        wt = m_busy && !x.done && (x.req || x.hilo);
        st = !x.rst && (lu || wt) && !x.br;
        o.pc_write     = !st;
        o.if_id_write  = !st;
        o.if_id_flush  = !x.rst && x.br;
        o.id_ex_flush  = (!x.rst && x.br) || st;
        o.mdu_start    = !x.rst && !m_busy && x.req && !st && !x.br;
        o.mdu_busy     = m_busy;
        o.mdu_timeout  = m_tmo;
        o.stall_cycles = 16'(m_stalls);
        return o;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_busy_cycles = 0; m_tmo = 0; m_stalls = 0;
    endtask

    // Advance the model across one rising edge with the inputs held during it.
    task automatic model_edge(in_t x);
        out_t o;
        if (x.rst) begin
            model_reset();
        end else begin
            o = predict(x);
            if (!o.pc_write && m_stalls < 65535) m_stalls++;
            if (m_busy) begin
                m_busy_cycles++;
                if (x.done) m_busy = 0;
                else if (m_busy_cycles == 64) begin m_busy = 0; m_tmo = 1; end
            end else if (o.mdu_start) begin
                m_busy = 1; m_busy_cycles = 0;
            end
        end
    endtask

    task automatic apply(in_t x);
        rst = x.rst; id_ex_mem_read = x.mr; id_ex_write_reg_addr = x.wr;
        if_id_instr_rs = x.rs; if_id_instr_rt = x.rt; if_id_uses_rt = x.urt;
        ex_branch_taken = x.br; id_mdu_req = x.req; id_hilo_read = x.hilo; mdu_done = x.done;
    endtask

    task automatic cycle(in_t x);
        @(posedge clk);
        #1;
        model_edge(prev);
        apply(x);
        if (x.rst) model_reset();
        exp_q.push_back(predict(x));
        prev = x;
    endtask

    function automatic in_t idle_in();
        in_t x;
        x = '0;
        return x;
    endfunction

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            out_t e;
            e = exp_q.pop_front();
            check("pc_write",     int'(pc_write),     int'(e.pc_write));
            check("if_id_write",  int'(if_id_write),  int'(e.if_id_write));
            check("if_id_flush",  int'(if_id_flush),  int'(e.if_id_flush));
            check("id_ex_flush",  int'(id_ex_flush),  int'(e.id_ex_flush));
            check("mdu_start",    int'(mdu_start),    int'(e.mdu_start));
            check("mdu_busy",     int'(mdu_busy),     int'(e.mdu_busy));
            check("mdu_timeout",  int'(mdu_timeout),  int'(e.mdu_timeout));
            check("stall_cycles", int'(stall_cycles), int'(e.stall_cycles));
        end
    end

    initial begin
        in_t x;
        int  done_div;
        prev = idle_in();
        prev.rst = 1;
        apply(prev);
        model_reset();

        x = idle_in(); x.rst = 1; x.mr = 1; x.wr = 5; x.rs = 5; x.br = 1; x.req = 1;
        cycle(x); cycle(x);
        cycle(idle_in());

        // load-use on rs, then zero-register and unused-rt cases
        x = idle_in(); x.mr = 1; x.wr = 5; x.rs = 5; cycle(x);
        cycle(idle_in());
        x = idle_in(); x.mr = 1; x.wr = 0; x.rs = 0; cycle(x);
        x = idle_in(); x.mr = 1; x.wr = 7; x.rt = 7; x.urt = 0; cycle(x);
        x.urt = 1; cycle(x);
        // branch beats load-use
        x = idle_in(); x.mr = 1; x.wr = 5; x.rs = 5; x.br = 1; cycle(x);

        // mult launch, mfhi waits 5 cycles, released on mdu_done
        x = idle_in(); x.req = 1; cycle(x);
        x = idle_in(); x.hilo = 1;
        repeat (5) cycle(x);
        x.done = 1; cycle(x);
        x = idle_in(); x.hilo = 1; cycle(x);

        // done while idle ignored; done with new req in BUSY launches next cycle
        x = idle_in(); x.done = 1; cycle(x);
        x = idle_in(); x.req = 1; cycle(x);
        x.done = 1; cycle(x);
        x.done = 0; cycle(x);
        x = idle_in(); x.done = 1; cycle(x);
        // branch does not cancel an outstanding op
        x = idle_in(); x.req = 1; cycle(x);
        x = idle_in(); x.br = 1; x.hilo = 1; cycle(x);
        x = idle_in(); x.done = 1; cycle(x);

        // timeout: start and never finish, mfhi pending throughout
        x = idle_in(); x.req = 1; cycle(x);
        x = idle_in(); x.hilo = 1;
        repeat (66) cycle(x);

        // reset in the middle of BUSY
        x = idle_in(); x.req = 1; cycle(x);
        x = idle_in(); x.hilo = 1; repeat (3) cycle(x);
        x.rst = 1; cycle(x);
        x = idle_in(); x.hilo = 1; repeat (3) cycle(x);

        // randomized traffic; done rarity varies so both completions and timeouts occur
        for (int ph = 0; ph < 3; ph++) begin
            done_div = (ph == 0) ? 4 : (ph == 1) ? 30 : 90;
            for (int n = 0; n < 900; n++) begin
                x.rst  = ($urandom_range(0, 249) == 0);
                x.mr   = $urandom_range(0, 1);
                x.wr   = 5'($urandom_range(0, 3));
                x.rs   = 5'($urandom_range(0, 3));
                x.rt   = 5'($urandom_range(0, 3));
                x.urt  = $urandom_range(0, 1);
                x.br   = ($urandom_range(0, 5) == 0);
                x.req  = ($urandom_range(0, 3) == 0);
                x.hilo = ($urandom_range(0, 2) == 0);
                x.done = ($urandom_range(0, done_div - 1) == 0);
                cycle(x);
            end
        end

        cycle(idle_in());
        @(posedge clk);
        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
